uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters. It sits between the requesters and the `uart_tx` `in_valid`/`in_ready`/`in_data` port. A granted requester keeps the transmitter until it sends its last byte or hits a length cap. Each packet can be prefixed with a source-ID header byte, so the far-end `uart_rx` consumer can demultiplex the streams.

---
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx byte port between NUM_REQ requesters.
// Optionally prefixes each packet with a source-ID header byte and force-releases at MAX_LEN beats.
module uart_tx_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter bit         ID_HEADER = 1'b1,
    parameter logic [7:0] ID_BASE   = 8'h30,
    parameter int         MAX_LEN   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 trunc
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               trunc_q, trunc_d;
    logic [IDX_W-1:0]   win;
    logic               found;
    logic [IDX_W-1:0]   idx_next;

    // Round-robin search starting at ptr_q; first valid requester wins.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                win   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign idx_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        trunc_d   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d   = win;
                    cnt_d   = '0;
                    state_d = ID_HEADER ? S_HEADER : S_DATA;
                end
            end
            S_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = ID_BASE + 8'(idx_q);
                if (tx_ready) state_d = S_DATA;
            end
            S_DATA: begin
                tx_valid         = req_valid[idx_q];
                tx_data          = req_data[8*idx_q +: 8];
                req_ready[idx_q] = tx_ready;
                if (req_valid[idx_q] && tx_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    // A last beat landing exactly on MAX_LEN is a normal end, not a truncation.
                    if (req_last[idx_q] || cnt_d == 8'(MAX_LEN)) begin
                        state_d = S_IDLE;
                        ptr_d   = idx_next;
                        trunc_d = !req_last[idx_q];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign grant = busy ? (NUM_REQ'(1) << idx_q) : '0;
    assign trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level owner/queue model.
module tb_uart_tx_arbiter;

    localparam int         NR   = 4;
    localparam bit         IDH  = 1'b1;
    localparam logic [7:0] BASE = 8'h30;
    localparam int         MAXL = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [8*NR-1:0]  req_data = '0;
    logic [NR-1:0]    req_last = '0;
    logic [NR-1:0]    req_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready = 1'b0;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             trunc;

    uart_tx_arbiter #(.NUM_REQ(NR), .ID_HEADER(IDH), .ID_BASE(BASE), .MAX_LEN(MAXL)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .grant(grant), .busy(busy), .trunc(trunc)
    );

    always #10 clk = ~clk;

    // Requester drivers
    bit         dv [NR];
    logic [7:0] dd [NR];
    bit         dl [NR];
    bit         rnd_mode = 1'b0;
    bit         rst_drv  = 1'b1;
    bit         rdy_drv  = 1'b0;

    // Reference model: current owner (-1 idle), header pending, beat count, rotation pointer
    int  m_owner = -1;
    bit  m_hdr   = 1'b0;
    int  m_cnt   = 0;
    int  m_ptr   = 0;
    bit  m_trunc = 1'b0;

    int         vectors = 0;
    int         errs    = 0;
    int         trunc_seen = 0;
    logic [7:0] txq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic          e_tv;
        logic [7:0]    e_td;
        logic [NR-1:0] e_rr, e_gr;
        logic          e_busy;
        int            o;
        bit            new_trunc;
        bit            fnd;
        @(negedge clk);
        reset    = rst_drv;
        tx_ready = rdy_drv;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = dv[i];
            req_data[8*i +: 8] = dd[i];
            req_last[i]        = dl[i];
        end
        #1;
        e_tv = 1'b0; e_td = '0; e_rr = '0; e_gr = '0; e_busy = 1'b0;
        if (m_owner >= 0) begin
            e_busy = 1'b1;
            e_gr   = NR'(1) << m_owner;
            if (m_hdr) begin
                e_tv = 1'b1;
                e_td = BASE + 8'(m_owner);
            end else begin
                e_tv = dv[m_owner];
                e_td = dd[m_owner];
                e_rr[m_owner] = rdy_drv;
            end
        end
        chk("tx_valid", tx_valid, e_tv);
        chk("tx_data", tx_data, e_td);
        chk("req_ready", req_ready, e_rr);
        chk("grant", grant, e_gr);
        chk("busy", busy, e_busy);
        chk("trunc", trunc, m_trunc);
        if (trunc) trunc_seen++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);

        o = m_owner;
        new_trunc = 1'b0;
        if (rst_drv) begin
            m_owner = -1; m_hdr = 1'b0; m_cnt = 0; m_ptr = 0;
        end else if (o < 0) begin
            fnd = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!fnd && dv[(m_ptr + k) % NR]) begin
                    fnd = 1'b1;
                    m_owner = (m_ptr + k) % NR;
                    m_hdr = IDH;
                    m_cnt = 0;
                end
            end
        end else if (m_hdr) begin
            if (rdy_drv) m_hdr = 1'b0;
        end else if (dv[o] && rdy_drv) begin
            m_cnt++;
            if (dl[o] || m_cnt == MAXL) begin
                new_trunc = !dl[o];
                m_ptr = (o + 1) % NR;
                m_owner = -1;
            end
        end
        m_trunc = rst_drv ? 1'b0 : new_trunc;

        for (int i = 0; i < NR; i++) begin
            if (dv[i] && e_rr[i]) dv[i] = 1'b0;
            if (rnd_mode && !dv[i] && $urandom_range(0, 2) == 0) begin
                dv[i] = 1'b1;
                dd[i] = 8'($urandom);
                dl[i] = ($urandom_range(0, 3) == 0);
            end
        end
        if (rnd_mode) begin
            rdy_drv = ($urandom_range(0, 9) < 7);
            rst_drv = ($urandom_range(0, 499) == 0);
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        for (int i = 0; i < NR; i++) dv[i] = 1'b0;
        step();
        step();
        rst_drv = 1'b0;
    endtask

    task automatic send_pkt(input int r, input logic [7:0] b0, input int n);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 200) begin
            if (!dv[r]) begin
                dv[r] = 1'b1;
                dd[r] = b0 + 8'(sent);
                dl[r] = (sent == n - 1);
                sent++;
            end
            step();
            guard++;
        end
        while (dv[r] && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            errs++;
            $display("FAIL send_pkt timeout: requester %0d still pending after %0d cycles", r, guard);
        end
        repeat (3) step();
    endtask

    task automatic chk_stream(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, txq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < txq.size(); i++)
            chk(name, txq[i], exp[i]);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < NR; i++) begin dv[i] = 1'b0; dd[i] = '0; dl[i] = 1'b0; end

        // Reset state
        do_reset();
        step();
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 4'b0000);

        // "HI" from requester 1
        rdy_drv = 1'b1;
        txq.delete();
        dv[1] = 1'b1; dd[1] = 8'h48; dl[1] = 1'b0;
        step();
        chk("hi_idle_grant", grant, 4'b0000);
        step();
        chk("hi_hdr_grant", grant, 4'b0010);
        chk("hi_hdr_data", tx_data, 8'h31);
        step();
        chk("hi_h_data", tx_data, 8'h48);
        chk("hi_h_ready", req_ready, 4'b0010);
        dv[1] = 1'b1; dd[1] = 8'h49; dl[1] = 1'b1;
        step();
        chk("hi_i_grant", grant, 4'b0010);
        step();
        chk("hi_end_grant", grant, 4'b0000);
        chk_stream("hi_stream", '{8'h31, 8'h48, 8'h49});

        // Simultaneous requests 0 and 2, then 0 re-requests immediately
        do_reset();
        rdy_drv = 1'b1;
        dv[0] = 1'b1; dd[0] = 8'hA0; dl[0] = 1'b1;
        dv[2] = 1'b1; dd[2] = 8'hC0; dl[2] = 1'b1;
        step();
        step();
        chk("rr_first", grant, 4'b0001);
        step();
        dv[0] = 1'b1; dd[0] = 8'hA1; dl[0] = 1'b1;
        step();
        chk("rr_gap", busy, 1'b0);
        step();
        chk("rr_second", grant, 4'b0100);
        step();
        step();
        step();
        chk("rr_third", grant, 4'b0001);
        repeat (3) step();

        // Owner 3 stalls mid-packet while requester 0 waits
        do_reset();
        rdy_drv = 1'b1;
        dv[3] = 1'b1; dd[3] = 8'h11; dl[3] = 1'b0;
        step();
        step();
        step();
        dv[0] = 1'b1; dd[0] = 8'h22; dl[0] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            chk("stall_grant", grant, 4'b1000);
            chk("stall_ready0", req_ready[0], 1'b0);
            chk("stall_txv", tx_valid, 1'b0);
        end
        dv[3] = 1'b1; dd[3] = 8'h12; dl[3] = 1'b1;
        step();
        step();
        step();
        chk("stall_next", grant, 4'b0001);
        repeat (4) step();

        // Truncation at MAX_LEN then exact-length packet
        do_reset();
        rdy_drv = 1'b1;
        txq.delete();
        t0 = trunc_seen;
        send_pkt(0, 8'hA0, 6);
        chk("trunc_count", trunc_seen - t0, 1);
        chk_stream("trunc_stream", '{8'h30, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h30, 8'hA4, 8'hA5});
        txq.delete();
        t0 = trunc_seen;
        send_pkt(1, 8'hB0, 4);
        chk("exact_trunc", trunc_seen - t0, 0);
        chk_stream("exact_stream", '{8'h31, 8'hB0, 8'hB1, 8'hB2, 8'hB3});

        // tx_ready held low during header
        do_reset();
        txq.delete();
        rdy_drv = 1'b0;
        dv[2] = 1'b1; dd[2] = 8'h55; dl[2] = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            step();
            chk("hdr_hold_v", tx_valid, 1'b1);
            chk("hdr_hold_d", tx_data, 8'h32);
        end
        rdy_drv = 1'b1;
        repeat (4) step();
        chk_stream("hdr_stream", '{8'h32, 8'h55});

        // Reset during DATA, then priority restarts at requester 0
        do_reset();
        rdy_drv = 1'b1;
        dv[3] = 1'b1; dd[3] = 8'h77; dl[3] = 1'b0;
        step();
        step();
        step();
        dv[3] = 1'b1; dd[3] = 8'h78; dl[3] = 1'b0;
        rdy_drv = 1'b0;
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        dv[3] = 1'b0;
        step();
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_txv", tx_valid, 1'b0);
        chk("mid_rst_rdy", req_ready, 4'b0000);
        dv[1] = 1'b1; dd[1] = 8'h01; dl[1] = 1'b1;
        dv[2] = 1'b1; dd[2] = 8'h02; dl[2] = 1'b1;
        rdy_drv = 1'b1;
        step();
        step();
        chk("post_rst_grant", grant, 4'b0010);
        repeat (8) step();

        // Randomized traffic
        rnd_mode = 1'b1;
        for (int c = 0; c < 4000; c++) step();
        rnd_mode = 1'b0;
        rst_drv  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
